// File: rtl/mirrored_counter_array_if.sv
// Command, fault-injection, read and status signals of the mirrored counter bank.
// The master side issues commands and reads; the slave side is the counter bank.
interface mirrored_counter_array_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned CHW = $clog2(NCH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CHW-1:0]   cmd_ch;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             inj_valid;
    logic [CHW-1:0]   inj_ch;
    logic [WIDTH-1:0] inj_mask;
    logic [CHW-1:0]   rd_ch;
    logic [WIDTH-1:0] rd_out;
    logic [WIDTH-1:0] rd_v;
    logic [WIDTH-1:0] rd_imp;
    logic             err_clr;
    logic [NCH-1:0]   err_mask;
    logic             busy;

    modport master (
        output cmd_valid, cmd_ch, cmd_op, cmd_data,
        output inj_valid, inj_ch, inj_mask,
        output rd_ch, err_clr,
        input  cmd_ready, rd_out, rd_v, rd_imp, err_mask, busy
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_op, cmd_data,
        input  inj_valid, inj_ch, inj_mask,
        input  rd_ch, err_clr,
        output cmd_ready, rd_out, rd_v, rd_imp, err_mask, busy
    );
endinterface

// File: rtl/mirrored_counter_array.sv
// Bank of up/down counters, each stored as a value plus a bit-inverted shadow copy.
// A background scrubber checks the shadow against the value, repairs it and logs violations.
module mirrored_counter_array #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned NCH          = 4,
    parameter int unsigned SAT          = 0,
    parameter int unsigned SCRUB_PERIOD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    mirrored_counter_array_if.slave   bus
);
    localparam int unsigned CHW = $clog2(NCH);
    localparam int unsigned TW  = $clog2(SCRUB_PERIOD);

    localparam logic [WIDTH-1:0] AllOnes   = '1;
    localparam logic [WIDTH-1:0] One       = WIDTH'(1);
    localparam logic [CHW-1:0]   LastCh    = CHW'(NCH - 1);
    localparam logic [TW-1:0]    LastTick  = TW'(SCRUB_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StRepair
    } state_e;

    state_e           state_q, state_d;
    logic [CHW-1:0]   idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] v_q   [NCH];
    logic [WIDTH-1:0] v_d   [NCH];
    logic [WIDTH-1:0] imp_q [NCH];
    logic [WIDTH-1:0] imp_d [NCH];
    logic [NCH-1:0]   err_q, err_d;
    logic [NCH-1:0]   err_set;
    logic             cmd_acc;
    logic             scan_ok;

    assign bus.cmd_ready = (state_q != StRepair);
    assign cmd_acc       = bus.cmd_valid & bus.cmd_ready;
    assign scan_ok       = (v_q[idx_q] == ~imp_q[idx_q]);

    // Value/shadow datapath: command, then injection, then repair (repair wins).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            v_d[i]   = v_q[i];
            imp_d[i] = imp_q[i];
        end
        err_set = '0;

        if (cmd_acc) begin
            unique case (bus.cmd_op)
                2'b00: begin
                    if (!(SAT != 0 && v_q[bus.cmd_ch] == AllOnes)) begin
                        v_d[bus.cmd_ch]   = v_q[bus.cmd_ch] + One;
                        imp_d[bus.cmd_ch] = imp_q[bus.cmd_ch] - One;
                    end
                end
                2'b01: begin
                    if (!(SAT != 0 && v_q[bus.cmd_ch] == '0)) begin
                        v_d[bus.cmd_ch]   = v_q[bus.cmd_ch] - One;
                        imp_d[bus.cmd_ch] = imp_q[bus.cmd_ch] + One;
                    end
                end
                2'b10: begin
                    v_d[bus.cmd_ch]   = bus.cmd_data;
                    imp_d[bus.cmd_ch] = ~bus.cmd_data;
                end
                2'b11: begin
                    v_d[bus.cmd_ch]   = '0;
                    imp_d[bus.cmd_ch] = AllOnes;
                end
            endcase
        end

        if (bus.inj_valid) begin
            imp_d[bus.inj_ch] = imp_d[bus.inj_ch] ^ bus.inj_mask;
        end

        if (state_q == StRepair) begin
            imp_d[idx_q]   = ~v_q[idx_q];
            err_set[idx_q] = 1'b1;
        end
    end

    // Set has priority over a same-cycle clear.
    assign err_d = (bus.err_clr ? '0 : err_q) | err_set;

    // Scrub sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;

        unique case (state_q)
            StIdle: begin
                if (timer_q == LastTick) begin
                    state_d = StScan;
                    idx_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StScan: begin
                // A command hitting the channel under test defers its check by a cycle.
                if (cmd_acc && bus.cmd_ch == idx_q) begin
                    state_d = StScan;
                end else if (!scan_ok) begin
                    state_d = StRepair;
                end else if (idx_q == LastCh) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + CHW'(1);
                end
            end
            StRepair: begin
                if (idx_q == LastCh) begin
                    state_d = StIdle;
                end else begin
                    state_d = StScan;
                    idx_d   = idx_q + CHW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            timer_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                v_q[i]   <= '0;
                imp_q[i] <= AllOnes;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            for (int i = 0; i < NCH; i++) begin
                v_q[i]   <= v_d[i];
                imp_q[i] <= imp_d[i];
            end
        end
    end

    assign bus.rd_v     = v_q[bus.rd_ch];
    assign bus.rd_imp   = imp_q[bus.rd_ch];
    assign bus.rd_out   = v_q[bus.rd_ch] & ~imp_q[bus.rd_ch];
    assign bus.err_mask = err_q;
    assign bus.busy     = (state_q != StIdle);
endmodule
